vjtag_tx: RTL and testbench
===========================

VJTAG_TX -- requirements
Module: vjtag_tx

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of byte entries buffered for transmission (power of two, 2..16).
REQ-002 Port: tck  input  1  sole clock; virtual JTAG test clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous to tck, active-low.
REQ-004 Port: ir_in  input  1  1 = TX data register selected, 0 = bypass.
REQ-005 Port: v_cdr  input  1  virtual Capture-DR state strobe.
REQ-006 Port: v_sdr  input  1  virtual Shift-DR state strobe.
REQ-007 Port: tdi  input  1  JTAG serial data in.
REQ-008 Port: tdo  output  1  JTAG serial data out.
REQ-009 Port: iDATA  input  8  byte to transmit.
REQ-010 Port: iVALID  input  1  iDATA valid; byte accepted on a cycle with iVALID & oREADY.
REQ-011 Port: oREADY  output  1  FIFO not full.
REQ-012 Port: oLEVEL  output  5  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-013 Frame SHALL be 9 bits, shifted LSB first: bit0 = VALID flag, bits1..8 = data[0..7].
REQ-014 Frame load: SHALL occur on a rising tck with ir_in & v_cdr, or with ir_in & v_sdr & bit counter at last bit.
REQ-015 Frame load with FIFO non-empty SHALL pop the head byte into the frame with VALID=1; with FIFO empty it SHALL load all-zero frame (VALID=0) and pop nothing.
REQ-016 On frame load bit counter SHALL be set to 0; on other ir_in & v_sdr cycles shift register SHALL shift right filling 0 and counter SHALL increment.
REQ-017 With ir_in=1, tdo SHALL equal shift register bit0 combinationally.
REQ-018 With ir_in=0, a bypass flop SHALL capture tdi every tck and tdo SHALL equal that flop (one-cycle delay).
REQ-019 With ir_in=0, shift register, counter and FIFO read side SHALL hold.
REQ-020 oREADY SHALL be !full; push on full SHALL be ignored even if a pop occurs in the same cycle.
REQ-021 Simultaneous push and pop on non-full, non-empty FIFO SHALL keep oLEVEL unchanged; push to empty FIFO coinciding with a load SHALL yield VALID=0 frame and oLEVEL=1.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; oLEVEL SHALL never exceed FIFO_DEPTH.
REQ-023 v_cdr mid-frame SHALL abandon the partial frame (its byte is lost) and load a fresh one.
REQ-024 v_cdr and v_sdr asserted together SHALL be treated as v_cdr.

Reset
REQ-025 With rst_n=0 at a tck edge: FIFO emptied, oLEVEL=0, oREADY=1 from next cycle, shift register=0, counter=0, bypass flop=0, so tdo=0.
REQ-026 Reset mid-frame SHALL discard the in-flight frame; no pop SHALL occur during reset.

Configuration
REQ-027 Macro VJTAG_TX_PARITY_EN defined: frame SHALL be 10 bits, bit9 = odd parity over bits0..8; counter last bit = 9.
REQ-028 Macro undefined: 9-bit frame exactly as REQ-013, no parity logic.

Structure
REQ-029 Package vjtag_pkg SHALL hold frame width constants (with/without parity), VALID bit index, and IR select encoding.
REQ-030 FIFO SHALL be sub-module vjtag_tx_fifo (synchronous, single-clock, push/pop/full/empty/level); framing and bypass live in vjtag_tx.

Verification
REQ-031 Push 0xA5, pulse v_cdr with ir_in=1, 8 v_sdr cycles -> tdo sequence 1,1,0,1,0,0,1,0,1; oLEVEL 1 -> 0 at load.
REQ-032 FIFO empty, v_cdr then 9 v_sdr -> tdo all 0; oLEVEL stays 0; next frame with 0x3C pushed meanwhile -> VALID=1, data 0x3C.
REQ-033 Push 5 bytes 0x01..0x05 with FIFO_DEPTH=4, no shifting -> 4 accepted, oREADY=0 after 4th, 0x05 dropped; drain 4 frames -> 0x01..0x04, 5th frame VALID=0.
REQ-034 ir_in=0, drive tdi pattern 1,0,1,1 -> tdo 0,1,0,1,1 (one-cycle delay); oLEVEL unchanged.
REQ-035 Assert rst_n=0 after 4 shift bits of frame 0x77 with 2 bytes queued -> tdo=0, oLEVEL=0, oREADY=1; next v_cdr loads VALID=0 frame.
REQ-036 VJTAG_TX_PARITY_EN defined, push 0x00 -> 10-bit frame 1,0,0,0,0,0,0,0,0,0 (bit9=0 since bits0..8 hold one 1); push 0x01 -> bit9=1.

Source files
------------

// File: rtl/vjtag_pkg.sv
// rtl/vjtag_pkg.sv - shared constants for the virtual JTAG byte transmitter
// Frame width depends on VJTAG_TX_PARITY_EN (adds an odd-parity bit 9).
package vjtag_pkg;

    localparam int FRAME_W_NOPAR = 9;
    localparam int FRAME_W_PAR   = 10;

`ifdef VJTAG_TX_PARITY_EN
    localparam int FRAME_W = FRAME_W_PAR;
`else
    localparam int FRAME_W = FRAME_W_NOPAR;
`endif

    localparam int VALID_BIT = 0;
    localparam int DATA_LSB  = 1;
    localparam int CNT_W     = 4;
    localparam int LEVEL_W   = 5;

    localparam logic IR_SEL_TX     = 1'b1;
    localparam logic IR_SEL_BYPASS = 1'b0;

endpackage

// File: rtl/vjtag_tx_fifo.sv
// rtl/vjtag_tx_fifo.sv - single-clock byte FIFO feeding the JTAG frame loader
// Push on full is dropped even if a pop happens in the same cycle.
module vjtag_tx_fifo
    import vjtag_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [7:0]         push_data_i,
    input  logic               pop_i,
    output logic [7:0]         pop_data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [LEVEL_W-1:0] level_o
);

    logic [7:0]         mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [LEVEL_W-1:0] level_q;
    logic               do_push;
    logic               do_pop;

    assign full_o     = (level_q == LEVEL_W'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (do_push && rst_n) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_q + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
        end
    end

endmodule

// File: rtl/vjtag_tx.sv
// rtl/vjtag_tx.sv - virtual JTAG TX data register: FIFO-fed framed bytes out on tdo
// Optional macro VJTAG_TX_PARITY_EN extends the frame with an odd-parity bit.
module vjtag_tx
    import vjtag_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               tck,
    input  logic               rst_n,
    input  logic               ir_in,
    input  logic               v_cdr,
    input  logic               v_sdr,
    input  logic               tdi,
    output logic               tdo,
    input  logic [7:0]         iDATA,
    input  logic               iVALID,
    output logic               oREADY,
    output logic [LEVEL_W-1:0] oLEVEL
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    logic [FRAME_W-1:0] sr_q;
    logic [FRAME_W-1:0] sr_d;
    logic [FRAME_W-1:0] frame_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               byp_q;
    logic               tx_sel;
    logic               load;
    logic               shift;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [7:0]         fifo_data;

    vjtag_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (tck),
        .rst_n       (rst_n),
        .push_i      (iVALID),
        .push_data_i (iDATA),
        .pop_i       (pop),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (oLEVEL)
    );

    assign oREADY = ~fifo_full;
    assign tx_sel = (ir_in == IR_SEL_TX);
    // v_cdr dominates v_sdr and abandons any partially shifted frame.
    assign load   = tx_sel & (v_cdr | (v_sdr & (cnt_q == LAST_BIT)));
    assign shift  = tx_sel & v_sdr & ~load;
    assign pop    = load & ~fifo_empty;
    assign tdo    = tx_sel ? sr_q[0] : byp_q;

    always_comb begin
        frame_d                    = '0;
        frame_d[VALID_BIT]         = 1'b1;
        frame_d[DATA_LSB +: 8]     = fifo_data;
`ifdef VJTAG_TX_PARITY_EN
        frame_d[FRAME_W-1]         = ~^frame_d[FRAME_W-2:0];
`endif
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = pop ? frame_d : '0;
            cnt_d = '0;
        end else if (shift) begin
            sr_d  = {1'b0, sr_q[FRAME_W-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge tck) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
            byp_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            if (ir_in == IR_SEL_BYPASS) begin
                byp_q <= tdi;
            end
        end
    end

endmodule

// File: tb/tb_vjtag_tx.sv
// tb/tb_vjtag_tx.sv - scoreboard bench for vjtag_tx (frame width follows VJTAG_TX_PARITY_EN)
module tb_vjtag_tx;

`ifdef VJTAG_TX_PARITY_EN
    localparam int FW = 10;
`else
    localparam int FW = 9;
`endif
    localparam int DEPTH = 4;

    logic       tck = 1'b0;
    logic       rst_n;
    logic       ir_in;
    logic       v_cdr;
    logic       v_sdr;
    logic       tdi;
    logic       tdo;
    logic [7:0] iDATA;
    logic       iVALID;
    logic       oREADY;
    logic [4:0] oLEVEL;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] model_q[$];
    logic       exp_bits[$];
    logic       got_bits[$];

    vjtag_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .tck    (tck),
        .rst_n  (rst_n),
        .ir_in  (ir_in),
        .v_cdr  (v_cdr),
        .v_sdr  (v_sdr),
        .tdi    (tdi),
        .tdo    (tdo),
        .iDATA  (iDATA),
        .iVALID (iVALID),
        .oREADY (oREADY),
        .oLEVEL (oLEVEL)
    );

    always #5 tck = ~tck;

    function automatic logic [FW-1:0] mk_frame(input logic [7:0] d);
        logic [8:0] base;
        base = {d, 1'b1};
`ifdef VJTAG_TX_PARITY_EN
        return {~^base, base};
`else
        return base;
`endif
    endfunction

    task automatic cyc();
        @(posedge tck);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ir_in = 1'b1; v_cdr = 1'b0; v_sdr = 1'b0;
        tdi = 1'b0; iVALID = 1'b0; iDATA = 8'h00;
        cyc();
        cyc();
        rst_n = 1'b1;
        model_q.delete();
        exp_bits.delete();
    endtask

    task automatic push_byte(input logic [7:0] d);
        iVALID = 1'b1;
        iDATA  = d;
        if (model_q.size() < DEPTH) model_q.push_back(d);
        cyc();
        iVALID = 1'b0;
    endtask

    // Loads one frame via v_cdr (optionally pushing at the load edge) and captures its FW tdo bits.
    task automatic read_frame(input bit push_en, input logic [7:0] pd);
        logic [FW-1:0] f;
        f = '0;
        if (model_q.size() > 0) f = mk_frame(model_q.pop_front());
        for (int i = 0; i < FW; i++) exp_bits.push_back(f[i]);
        if (push_en && model_q.size() < DEPTH) model_q.push_back(pd);
        ir_in = 1'b1; v_cdr = 1'b1; v_sdr = 1'b0;
        iVALID = push_en; iDATA = pd;
        cyc();
        v_cdr = 1'b0; iVALID = 1'b0;
        got_bits.delete();
        got_bits.push_back(tdo);
        v_sdr = 1'b1;
        for (int i = 1; i < FW; i++) begin
            cyc();
            got_bits.push_back(tdo);
        end
        v_sdr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (tdo !== 1'b0) $display("FAIL reset_tdo: got %b expected 0", tdo); else pass_cnt++;
        total_cnt++;
        if (oLEVEL !== 5'd0) $display("FAIL reset_level: got %0d expected 0", oLEVEL); else pass_cnt++;
        total_cnt++;
        if (oREADY !== 1'b1) $display("FAIL reset_ready: got %b expected 1", oREADY); else pass_cnt++;
    endtask

    task automatic test_basic_frame();
        logic e;
        do_reset();
        push_byte(8'hA5);
        total_cnt++;
        if (oLEVEL !== 5'd1) $display("FAIL basic_level_pre: got %0d expected 1", oLEVEL); else pass_cnt++;
        read_frame(1'b0, 8'h00);
        total_cnt++;
        if (oLEVEL !== 5'd0) $display("FAIL basic_level_post: got %0d expected 0", oLEVEL); else pass_cnt++;
        for (int i = 0; i < FW; i++) begin
            e = exp_bits.pop_front();
            total_cnt++;
            if (got_bits[i] !== e) $display("FAIL basic_bit%0d: got %b expected %b", i, got_bits[i], e);
            else pass_cnt++;
        end
    endtask

    task automatic test_empty_frame();
        logic e;
        do_reset();
        // Empty FIFO with a push landing on the load edge: VALID=0 frame, byte kept.
        read_frame(1'b1, 8'h3C);
        total_cnt++;
        if (oLEVEL !== 5'd1) $display("FAIL empty_level: got %0d expected 1", oLEVEL); else pass_cnt++;
        for (int i = 0; i < FW; i++) begin
            e = exp_bits.pop_front();
            total_cnt++;
            if (got_bits[i] !== e) $display("FAIL empty_bit%0d: got %b expected %b", i, got_bits[i], e);
            else pass_cnt++;
        end
        read_frame(1'b0, 8'h00);
        for (int i = 0; i < FW; i++) begin
            e = exp_bits.pop_front();
            total_cnt++;
            if (got_bits[i] !== e) $display("FAIL next3c_bit%0d: got %b expected %b", i, got_bits[i], e);
            else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        logic e;
        do_reset();
        for (int b = 1; b <= 5; b++) begin
            push_byte(8'(b));
            if (b == 4) begin
                total_cnt++;
                if (oREADY !== 1'b0) $display("FAIL ovf_ready: got %b expected 0", oREADY); else pass_cnt++;
            end
        end
        total_cnt++;
        if (oLEVEL !== 5'd4) $display("FAIL ovf_level: got %0d expected 4", oLEVEL); else pass_cnt++;
        for (int fr = 0; fr < 5; fr++) begin
            read_frame(1'b0, 8'h00);
            for (int i = 0; i < FW; i++) begin
                e = exp_bits.pop_front();
                total_cnt++;
                if (got_bits[i] !== e)
                    $display("FAIL ovf_f%0d_bit%0d: got %b expected %b", fr, i, got_bits[i], e);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] f;
        logic e;
        do_reset();
        push_byte(8'h5A);
        push_byte(8'hC3);
        f = mk_frame(model_q.pop_front());
        for (int i = 0; i < FW; i++) exp_bits.push_back(f[i]);
        got_bits.delete();
        ir_in = 1'b1; v_cdr = 1'b1;
        cyc();
        v_cdr = 1'b0;
        got_bits.push_back(tdo);
        v_sdr = 1'b1;
        for (int i = 1; i < FW; i++) begin
            cyc();
            got_bits.push_back(tdo);
        end
        // Reload from the counter with a simultaneous push.
        f = mk_frame(model_q.pop_front());
        for (int i = 0; i < FW; i++) exp_bits.push_back(f[i]);
        model_q.push_back(8'h11);
        iVALID = 1'b1; iDATA = 8'h11;
        cyc();
        iVALID = 1'b0;
        got_bits.push_back(tdo);
        total_cnt++;
        if (oLEVEL !== 5'd1) $display("FAIL b2b_level: got %0d expected 1", oLEVEL); else pass_cnt++;
        for (int i = 1; i < FW; i++) begin
            cyc();
            got_bits.push_back(tdo);
        end
        v_sdr = 1'b0;
        for (int i = 0; i < 2 * FW; i++) begin
            e = exp_bits.pop_front();
            total_cnt++;
            if (got_bits[i] !== e) $display("FAIL b2b_bit%0d: got %b expected %b", i, got_bits[i], e);
            else pass_cnt++;
        end
    endtask

    task automatic test_bypass();
        logic pat [4];
        logic e;
        do_reset();
        push_byte(8'h96);
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
        ir_in = 1'b0; v_sdr = 1'b1; tdi = 1'b0;
        cyc();
        exp_bits.push_back(1'b0);
        got_bits.delete();
        got_bits.push_back(tdo);
        for (int i = 0; i < 4; i++) begin
            tdi = pat[i];
            exp_bits.push_back(pat[i]);
            cyc();
            got_bits.push_back(tdo);
        end
        v_sdr = 1'b0; tdi = 1'b0;
        for (int i = 0; i < 5; i++) begin
            e = exp_bits.pop_front();
            total_cnt++;
            if (got_bits[i] !== e) $display("FAIL byp_tdo%0d: got %b expected %b", i, got_bits[i], e);
            else pass_cnt++;
        end
        total_cnt++;
        if (oLEVEL !== 5'd1) $display("FAIL byp_level: got %0d expected 1", oLEVEL); else pass_cnt++;
        read_frame(1'b0, 8'h00);
        for (int i = 0; i < FW; i++) begin
            e = exp_bits.pop_front();
            total_cnt++;
            if (got_bits[i] !== e) $display("FAIL byp_hold_bit%0d: got %b expected %b", i, got_bits[i], e);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midframe();
        logic [FW-1:0] f;
        logic e;
        do_reset();
        push_byte(8'h77);
        push_byte(8'h12);
        push_byte(8'h34);
        f = mk_frame(model_q.pop_front());
        for (int i = 0; i < 5; i++) exp_bits.push_back(f[i]);
        got_bits.delete();
        ir_in = 1'b1; v_cdr = 1'b1;
        cyc();
        v_cdr = 1'b0;
        got_bits.push_back(tdo);
        total_cnt++;
        if (oLEVEL !== 5'd2) $display("FAIL mid_level_pre: got %0d expected 2", oLEVEL); else pass_cnt++;
        v_sdr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            got_bits.push_back(tdo);
        end
        for (int i = 0; i < 5; i++) begin
            e = exp_bits.pop_front();
            total_cnt++;
            if (got_bits[i] !== e) $display("FAIL mid_bit%0d: got %b expected %b", i, got_bits[i], e);
            else pass_cnt++;
        end
        v_sdr = 1'b0; rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        model_q.delete();
        total_cnt++;
        if (tdo !== 1'b0) $display("FAIL mid_rst_tdo: got %b expected 0", tdo); else pass_cnt++;
        total_cnt++;
        if (oLEVEL !== 5'd0) $display("FAIL mid_rst_level: got %0d expected 0", oLEVEL); else pass_cnt++;
        total_cnt++;
        if (oREADY !== 1'b1) $display("FAIL mid_rst_ready: got %b expected 1", oREADY); else pass_cnt++;
        read_frame(1'b0, 8'h00);
        for (int i = 0; i < FW; i++) begin
            e = exp_bits.pop_front();
            total_cnt++;
            if (got_bits[i] !== e) $display("FAIL mid_next_bit%0d: got %b expected %b", i, got_bits[i], e);
            else pass_cnt++;
        end
    endtask

`ifdef VJTAG_TX_PARITY_EN
    task automatic test_parity();
        do_reset();
        push_byte(8'h00);
        read_frame(1'b0, 8'h00);
        exp_bits.delete();
        total_cnt++;
        if (got_bits[9] !== 1'b0) $display("FAIL par_00: got %b expected 0", got_bits[9]); else pass_cnt++;
        push_byte(8'h01);
        read_frame(1'b0, 8'h00);
        exp_bits.delete();
        total_cnt++;
        if (got_bits[9] !== 1'b1) $display("FAIL par_01: got %b expected 1", got_bits[9]); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_empty_frame();
        test_overflow();
        test_back_to_back();
        test_bypass();
        test_reset_midframe();
`ifdef VJTAG_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
